// File: rtl/imm_pkg.sv
// Immediate-format select codes shared by the immediate generator and decoder control.
package imm_pkg;

    localparam int unsigned IMM_SEL_W = 3;

    localparam logic [IMM_SEL_W-1:0] IMM_I  = 3'b000;
    localparam logic [IMM_SEL_W-1:0] IMM_B  = 3'b001;
    localparam logic [IMM_SEL_W-1:0] IMM_J  = 3'b010;
    localparam logic [IMM_SEL_W-1:0] IMM_S  = 3'b011;
    localparam logic [IMM_SEL_W-1:0] IMM_U  = 3'b100;
    localparam logic [IMM_SEL_W-1:0] IMM_Z  = 3'b101;
    localparam logic [IMM_SEL_W-1:0] IMM_C4 = 3'b110;
    localparam logic [IMM_SEL_W-1:0] IMM_SH = 3'b111;

endpackage

// File: rtl/imm_extract.sv
// Combinational instruction + format select -> XLEN-wide immediate (XLEN = 32 or 64).
module imm_extract
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]          instr_i,
    input  logic [IMM_SEL_W-1:0] sel_i,
    output logic [XLEN-1:0]      imm_c
);

    // Signed formats are built at 32 bits, then sign-extended by the sized cast.
    logic signed [31:0] sx32;

    always_comb begin
        sx32  = '0;
        imm_c = '0;
        unique case (sel_i)
            IMM_I: begin
                sx32  = {{20{instr_i[31]}}, instr_i[31:20]};
                imm_c = XLEN'(sx32);
            end
            IMM_B: begin
                sx32  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                         instr_i[11:8], 1'b0};
                imm_c = XLEN'(sx32);
            end
            IMM_J: begin
                sx32  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                         instr_i[30:21], 1'b0};
                imm_c = XLEN'(sx32);
            end
            IMM_S: begin
                sx32  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                imm_c = XLEN'(sx32);
            end
            IMM_U: begin
                sx32  = {instr_i[31:12], 12'h000};
                imm_c = XLEN'(sx32);
            end
            IMM_Z:  imm_c = XLEN'(instr_i[19:15]);
            IMM_C4: imm_c = XLEN'(4);
            IMM_SH: imm_c = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
            default: imm_c = '0;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: valid/ready input, 2-entry skid buffer on the output.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMM_SEL_W-1:0] in_imm_sel,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [TAG_W-1:0]     out_tag
);

    logic [XLEN-1:0]  ext_imm;
    logic             accept;
    logic             main_take;

    logic             main_valid_q, main_valid_d;
    logic [XLEN-1:0]  main_imm_q,   main_imm_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i (in_instr),
        .sel_i   (in_imm_sel),
        .imm_c   (ext_imm)
    );

    assign accept    = in_valid & ~skid_valid_q;
    assign main_take = ~main_valid_q | out_ready;

    // Next-state: flush beats everything; the skid entry always drains before new input.
    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_tag_d   = skid_tag_q;

        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_take) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_tag_d   = skid_tag_q;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_imm_d = ext_imm;
                    main_tag_d = in_tag;
                end
            end
            skid_valid_d = 1'b0;
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_imm   = main_imm_q;
    assign out_tag   = main_tag_q;

endmodule
